// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
// Mode encoding, stage-count calculation and the width/chunk sanity check.
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int calc_stages(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

  function automatic bit chunk_ok(
    input int width,
    input int chunk
  );
    return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple adder slice.
// Ports: cin, a, b in; s, cout, c_msb_in (carry into slice MSB) out.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// WIDTH-bit add/sub, one CHUNK-bit ripple slice per pipeline stage.
// Ports: clk, rst, in_* valid/ready beat, out_* valid/ready result+flags.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic                          adv;
  logic                          is_sub;
  logic                          cin0;
  logic [WIDTH-1:0]              y_eff;

  logic [WIDTH-1:0]              xr [STAGES];
  logic [WIDTH-1:0]              yr [STAGES];
  logic [WIDTH-1:0]              sr [STAGES];
  logic [STAGES-1:0]             cr;
  logic [STAGES-1:0]             vr;
  logic                          ovf_r;

  logic [STAGES-1:0][WIDTH-1:0]  ns_w;
  logic [STAGES-1:0]             co_w;
  logic [STAGES-1:0]             cm_w;

  assign is_sub = (mode_e'(in_sub) == SUB);
  assign cin0   = is_sub ? ~in_carry : in_carry;
  assign y_eff  = is_sub ? ~in_y : in_y;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;

    logic [CHUNK-1:0] a;
    logic [CHUNK-1:0] b;
    logic [CHUNK-1:0] s;
    logic             ci;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] acc;

    if (k == 0) begin : g_first
      assign a    = in_x[LO +: CHUNK];
      assign b    = y_eff[LO +: CHUNK];
      assign ci   = cin0;
      assign prev = '0;
    end else begin : g_next
      assign a    = xr[k-1][LO +: CHUNK];
      assign b    = yr[k-1][LO +: CHUNK];
      assign ci   = cr[k-1];
      assign prev = sr[k-1];
    end

    adder_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .cin      (ci),
      .a        (a),
      .b        (b),
      .s        (s),
      .cout     (co_w[k]),
      .c_msb_in (cm_w[k])
    );

    // lower slices already complete, upper bits still zero
    always_comb begin
      acc             = prev;
      acc[LO +: CHUNK] = s;
    end

    assign ns_w[k] = acc;
  end

  // one global stall: the whole pipe freezes while the result waits
  assign adv = ~vr[STAGES-1] | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vr           <= '0;
      cr           <= '0;
      ovf_r        <= 1'b0;
      sr[STAGES-1] <= '0;
    end else if (adv) begin
      vr[0] <= in_valid;
      xr[0] <= in_x;
      yr[0] <= y_eff;
      for (int k = 1; k < STAGES; k++) begin
        vr[k] <= vr[k-1];
      end
      for (int k = 1; k < STAGES - 1; k++) begin
        xr[k] <= xr[k-1];
        yr[k] <= yr[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        sr[k] <= ns_w[k];
      end
      cr    <= co_w;
      ovf_r <= cm_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  assign in_ready  = adv;
  assign out_valid = vr[STAGES-1];
  assign out_sum   = sr[STAGES-1];
  assign out_carry = cr[STAGES-1];
  assign out_ovf   = ovf_r;
  assign out_zero  = ~|sr[STAGES-1];

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised successor of the team's 8-bit ripple adder: a WIDTH-bit adder/subtractor split into CHUNK-bit ripple slices, with one register stage per slice.
- Carry propagates slice-to-slice across the pipeline registers, so throughput is one operation per clock.
- Valid/ready handshakes on input and output; output carries sum, carry/borrow, signed overflow and zero flags.
- Sits between operand sources (register file, accumulators) and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits summed per pipeline stage; STAGES = WIDTH/CHUNK (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_sub  input  1  0 = add, 1 = subtract (X - Y).
- in_carry  input  1  add: carry-in; sub: borrow-in (1 = borrow).
- in_x  input  WIDTH  operand X.
- in_y  input  WIDTH  operand Y.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts a result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  add: carry out of MSB; sub: 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Arithmetic:
  - Add: {carry,sum} = X + Y + in_carry.
  - Sub: Y is inverted and the effective cin = ~in_carry, so X - Y - in_carry.
  - out_carry = carry out of bit WIDTH-1, i.e. the true MSB carry, not the carry into the MSB.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage k (0..STAGES-1) sums slice k using the carry registered by stage k-1; stage 0 uses the effective cin.
  - Higher slices of X and inverted Y, plus completed lower sum slices, ride the pipe as skew registers.
  - Latency = STAGES cycles from an accepted beat to out_valid (4 for the defaults).
  - STAGES=1 gives a single registered ripple adder with latency 1.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - While advance is 0, every stage register and valid bit holds its value.
  - While advance is 1, each valid bit shifts forward; stage 0 valid loads in_valid.
  - Bubbles propagate as invalid stages. No beat is lost, duplicated or reordered.
  - out_* data is stable while out_valid & ~out_ready.
- Reset:
  - rst=1 clears all stage valid bits, so out_valid = 0 and in_ready = 1 on the next cycle.
  - rst=1 zeroes out_sum, out_carry, out_ovf; out_zero reads 1 (derived).
  - Reset mid-stream discards all in-flight beats; data registers other than outputs need no reset.
- Simultaneous events:
  - A beat may be accepted in the same cycle a result is consumed (full throughput).
  - rst dominates in_valid and out_ready.
- Flags are computed in the final stage and registered with out_sum; out_zero is a combinational NOR of the registered sum.

Decomposition:
- Package addsub_pkg holds:
  - Mode encodings ADD=0, SUB=1.
  - A function computing STAGES from WIDTH/CHUNK.
  - An elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module adder_slice: combinational CHUNK-bit ripple adder.
  - Inputs: cin, a, b. Outputs: s, cout, and c_msb_in (carry into the slice MSB, for overflow).
  - Instantiated STAGES times by a generate loop.

Test Plan:
- Add 0x00000001 + 0x00000003, carry 0 -> after 4 cycles sum 0x00000004, carry 0, ovf 0, zero 0.
- Add 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, carry 1, ovf 0, zero 1; then 0x7FFFFFFF + 1 -> sum 0x80000000, carry 0, ovf 1.
- Sub 5 - 7, borrow 0 -> sum 0xFFFFFFFE, carry 0 (borrow), ovf 0; then sub 7 - 5 with borrow 1 -> sum 0x00000001, carry 1.
- Back-to-back stream of 8 random ops with out_ready held 1 -> one result per cycle after 4-cycle fill, all matching the reference model in order.
- Stream 6 ops, drop out_ready for 3 cycles mid-stream -> in_ready low during the stall, out_sum stable, all 6 results delivered once, in order.
- Assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0, in_ready=1; none of the 3 results ever appear; a fresh beat then returns after 4 cycles.
